m_mem_arbiter: RTL and testbench
================================

// Module: m_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory (1-cycle read latency, 4K x 32) between the
//  instruction-fetch port (I) and the load/store port (D) of the processor.
//  Grants at most one access per cycle, steers the address, write-enable and write data to
//  the memory, and returns read data to the owning port with a valid strobe.
//  Fixed D-over-I priority, plus a starvation guard for I.
// PARAMETERS
//  ADDR_W     12  word-address width (memory depth = 2**ADDR_W)
//  DATA_W     32  data width
//  STARVE_MAX 4   consecutive D grants while I waits; the next arbitration cycle goes to I
// PORTS
//  w_clk      in   1       clock, all state updates on posedge
//  w_rst      in   1       synchronous active-high reset
//  w_ce       in   1       clock enable; 0 = no grants and all state held
//  w_i_req    in   1       I read request; held until w_i_gnt
//  w_i_addr   in   ADDR_W  I word address
//  w_i_gnt    out  1       I access issued this cycle (combinational)
//  w_i_rvalid out  1       I read data valid (registered)
//  w_i_rdata  out  DATA_W  I read data
//  w_d_req    in   1       D request; held with stable addr/we/wdata until w_d_gnt
//  w_d_we     in   1       1 = store, 0 = load
//  w_d_addr   in   ADDR_W  D word address
//  w_d_wdata  in   DATA_W  D store data
//  w_d_gnt    out  1       D access issued this cycle (combinational)
//  w_d_rvalid out  1       D load data valid (registered); never asserted for stores
//  w_d_rdata  out  DATA_W  D read data
//  w_m_addr   out  ADDR_W  memory address
//  w_m_we     out  1       memory write enable
//  w_m_din    out  DATA_W  memory write data
//  w_m_dout   in   DATA_W  memory read data, valid the cycle after the address is applied
// BEHAVIOUR
//  - Reset: grants 0, both rvalid 0, both rdata 0, starvation count 0, pending owner NONE.
//  - Grant (w_ce=1, not in reset): D only -> D; I only -> I; both -> D unless cnt==STARVE_MAX,
//    then I. At most one grant per cycle. w_m_* follow the granted port; with no grant,
//    w_m_we=0 and w_m_addr holds the I address.
//  - Starvation count: +1 on each D grant while w_i_req=1; cleared on any I grant or when
//    w_i_req=0. Saturates at STARVE_MAX.
//  - Latency: a read granted in cycle N gives <port>_rvalid=1 in cycle N+1 with
//    rdata=w_m_dout. rvalid is a 1-cycle pulse. rdata holds its value until that port's next
//    response.
//  - Pending-owner register: {NONE,I,D} is set on a granted read and set to NONE otherwise.
//    It steers w_m_dout and the rvalid pulse.
//  - A store granted in N is written at posedge end of N. A load of the same address granted in
//    N+1 returns the new data.
//  - w_ce=0: no grants, no write, owner/count/rdata held. A response already pending is
//    delivered when w_ce returns high. rvalid stays 0 while w_ce=0.
//  - Reset mid-read: the pending response is dropped and no rvalid follows.
//  - A request released without a grant is legal and leaves no state behind.
// STRUCTURE
//  - Shared header m_mem_defines.vh: OWN_NONE=2'd0, OWN_I=2'd1, OWN_D=2'd2; default
//    ADDR_W/DATA_W.
//  - One sub-module, m_arb_pick: combinational 2-way priority pick with starvation override,
//    inputs (i_req, d_req, starve), outputs (i_gnt, d_gnt).
//  - The owner/count/rdata registers live in the top.
// TESTING
//  1 I-only reads of addrs 0,1,2 (mem[k]=k+100) -> i_gnt each cycle; i_rvalid next cycle with
//    rdata 100,101,102.
//  2 I and D requesting together, D load of addr 5 -> D granted; d_rvalid next cycle with
//    mem[5]; I granted the cycle after.
//  3 D continuous, I held, STARVE_MAX=4 -> D,D,D,D,I,D... pattern; count back to 0 after the
//    I grant.
//  4 D store 0xDEADBEEF to addr 7, then D load of addr 7 next cycle -> d_rvalid with
//    0xDEADBEEF; no d_rvalid for the store.
//  5 I read granted, then w_rst=1 next cycle -> no i_rvalid; all outputs 0. w_ce=0 for 3
//    cycles with pending read -> i_rvalid only after w_ce=1.
//  6 Random I/D traffic with a reference model -> one grant per cycle max; every read gets
//    exactly one rvalid with correct data.

Source files
------------

// File: rtl/m_mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF / STARVE_MAX_DEF : default geometry and starvation limit
//   owner_e : which port owns the read currently in flight to the memory
package m_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF     = 12;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/m_mem_arbiter_pick.sv
// Two-way priority pick: D wins over I unless I has been starved.
//   i_req, d_req : qualified requests (already gated by enable/reset)
//   starve       : I has waited the maximum number of D grants
//   i_gnt, d_gnt : one-hot-or-zero grant (combinational)
module m_arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic starve,
  output logic i_gnt,
  output logic d_gnt
);

  always_comb begin
    d_gnt = d_req && !(i_req && starve);
    i_gnt = i_req && !d_gnt;
  end

endmodule

// File: rtl/m_mem_arbiter.sv
// Arbitrates one single-port synchronous memory (1-cycle read latency) between the
// instruction-fetch port (I) and the load/store port (D).
//   w_clk, w_rst (sync, active-high), w_ce (clock enable, 0 = hold everything)
//   I port : w_i_req, w_i_addr -> w_i_gnt, w_i_rvalid, w_i_rdata
//   D port : w_d_req, w_d_we, w_d_addr, w_d_wdata -> w_d_gnt, w_d_rvalid, w_d_rdata
//   Memory : w_m_addr, w_m_we, w_m_din -> w_m_dout
module m_mem_arbiter
  import m_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_ce,
  input  logic              w_i_req,
  input  logic [ADDR_W-1:0] w_i_addr,
  output logic              w_i_gnt,
  output logic              w_i_rvalid,
  output logic [DATA_W-1:0] w_i_rdata,
  input  logic              w_d_req,
  input  logic              w_d_we,
  input  logic [ADDR_W-1:0] w_d_addr,
  input  logic [DATA_W-1:0] w_d_wdata,
  output logic              w_d_gnt,
  output logic              w_d_rvalid,
  output logic [DATA_W-1:0] w_d_rdata,
  output logic [ADDR_W-1:0] w_m_addr,
  output logic              w_m_we,
  output logic [DATA_W-1:0] w_m_din,
  input  logic [DATA_W-1:0] w_m_dout
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic              active;
  logic              starve;
  logic              i_pick;
  logic              d_pick;
  logic [DATA_W-1:0] resp_data;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic              fresh_q, fresh_d;        // w_m_dout carries the read issued last cycle
  logic              held_q, held_d;          // hold_data_q has an undelivered response
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  assign active = w_ce && !w_rst;
  assign starve = (cnt_q == CNT_W'(STARVE_MAX));

  m_arb_pick u_pick (
    .i_req  (w_i_req && active),
    .d_req  (w_d_req && active),
    .starve (starve),
    .i_gnt  (i_pick),
    .d_gnt  (d_pick)
  );

  assign w_i_gnt = i_pick;
  assign w_d_gnt = d_pick;

  // Memory steering; with no grant the I address is presented.
  always_comb begin
    w_m_addr = d_pick ? w_d_addr : w_i_addr;
    w_m_we   = d_pick && w_d_we;
    w_m_din  = w_d_wdata;
  end

  // A response parked during a w_ce=0 stretch takes precedence over live memory data,
  // because the memory keeps reading whatever address is presented meanwhile.
  assign resp_data  = held_q ? hold_data_q : w_m_dout;
  assign w_i_rvalid = active && (owner_q == OWN_I);
  assign w_d_rvalid = active && (owner_q == OWN_D);
  assign w_i_rdata  = w_rst ? '0 : (w_i_rvalid ? resp_data : i_rdata_q);
  assign w_d_rdata  = w_rst ? '0 : (w_d_rvalid ? resp_data : d_rdata_q);

  // Next-state: starvation count, pending owner, response parking, held read data.
  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    fresh_d     = fresh_q;
    held_d      = held_q;
    hold_data_d = hold_data_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    if (active) begin
      if (i_pick || !w_i_req) begin
        cnt_d = '0;
      end else if (d_pick && !starve) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (i_pick) begin
        owner_d = OWN_I;
      end else if (d_pick && !w_d_we) begin
        owner_d = OWN_D;
      end else begin
        owner_d = OWN_NONE;
      end

      fresh_d = i_pick || (d_pick && !w_d_we);
      held_d  = 1'b0;
      if (w_i_rvalid) i_rdata_d = resp_data;
      if (w_d_rvalid) d_rdata_d = resp_data;
    end else begin
      fresh_d = 1'b0;
      if (fresh_q) begin
        held_d      = 1'b1;
        hold_data_d = w_m_dout;
      end
    end
  end

  // State registers.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt_q       <= '0;
      owner_q     <= OWN_NONE;
      fresh_q     <= 1'b0;
      held_q      <= 1'b0;
      hold_data_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      fresh_q     <= fresh_d;
      held_q      <= held_d;
      hold_data_q <= hold_data_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Self-checking bench for m_mem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbitration and memory rules.
module tb_m_mem_arbiter;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, ce;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [DATA_W-1:0] m_din;
  logic [DATA_W-1:0] m_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  m_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .w_clk(clk), .w_rst(rst), .w_ce(ce),
    .w_i_req(i_req), .w_i_addr(i_addr), .w_i_gnt(i_gnt), .w_i_rvalid(i_rvalid), .w_i_rdata(i_rdata),
    .w_d_req(d_req), .w_d_we(d_we), .w_d_addr(d_addr), .w_d_wdata(d_wdata),
    .w_d_gnt(d_gnt), .w_d_rvalid(d_rvalid), .w_d_rdata(d_rdata),
    .w_m_addr(m_addr), .w_m_we(m_we), .w_m_din(m_din), .w_m_dout(m_dout)
  );

  // External single-port memory, 1-cycle read latency, reads every cycle.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    m_dout <= mem[m_addr];
    if (m_we) mem[m_addr] = m_din;
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int unsigned       cnt;
  bit                pend_v;
  bit                pend_is_d;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] hold_i, hold_d;
  logic              e_i_gnt, e_d_gnt, e_i_rvalid, e_d_rvalid, e_m_we;
  logic [DATA_W-1:0] e_i_rdata, e_d_rdata;

  // One cycle of the model: pending response delivered on the next enabled cycle,
  // D over I unless I has waited STARVE_MAX D grants.
  task automatic model_step();
    e_i_gnt = 0; e_d_gnt = 0; e_i_rvalid = 0; e_d_rvalid = 0; e_m_we = 0;
    if (rst) begin
      cnt = 0; pend_v = 0; hold_i = '0; hold_d = '0;
    end else if (ce) begin
      if (pend_v) begin
        if (pend_is_d) begin e_d_rvalid = 1; hold_d = pend_data; end
        else           begin e_i_rvalid = 1; hold_i = pend_data; end
      end
      pend_v = 0;
      if (d_req && i_req) begin
        if (cnt == STARVE_MAX) e_i_gnt = 1; else e_d_gnt = 1;
      end else if (d_req) e_d_gnt = 1;
      else if (i_req) e_i_gnt = 1;
      if (e_i_gnt || !i_req) cnt = 0;
      else if (e_d_gnt && cnt < STARVE_MAX) cnt = cnt + 1;
      if (e_i_gnt) begin pend_v = 1; pend_is_d = 0; pend_data = ref_mem[i_addr]; end
      if (e_d_gnt) begin
        if (d_we) begin e_m_we = 1; ref_mem[d_addr] = d_wdata; end
        else begin pend_v = 1; pend_is_d = 1; pend_data = ref_mem[d_addr]; end
      end
    end
    e_i_rdata = hold_i;
    e_d_rdata = hold_d;
  endtask

  // Drive one cycle of inputs just after the edge, advance the model, wait to mid-cycle.
  task automatic cyc(input logic r, input logic c, input logic ir, input logic [ADDR_W-1:0] ia,
                     input logic dr, input logic dwe, input logic [ADDR_W-1:0] da,
                     input logic [DATA_W-1:0] dw);
    @(posedge clk); #1;
    rst = r; ce = c; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] got;
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 1, 12'd3, 1, 0, 12'd4, '0);
      got = {i_gnt, d_gnt, i_rvalid, d_rvalid, m_we};
      total++;
      if (got !== 5'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 00000", got); end
      total++;
      if (i_rdata !== '0 || d_rdata !== '0) begin
        bad++; $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata);
      end
    end
    cyc(0, 1, 0, '0, 0, 0, '0, '0);
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b00 || i_rdata !== '0 || d_rdata !== '0) begin
      bad++; $display("FAIL post_reset: got rv=%b%b i=%h d=%h want 00 0 0", i_rvalid, d_rvalid, i_rdata, d_rdata);
    end
  endtask

  task automatic test_i_reads();
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, k < 3, ADDR_W'(k), 0, 0, '0, '0);
      total++;
      if (i_gnt !== (k < 3) || d_gnt !== 1'b0) begin
        bad++; $display("FAIL i_read_gnt[%0d]: got i=%b d=%b want i=%b d=0", k, i_gnt, d_gnt, k < 3);
      end
      total++;
      if (i_rvalid !== (k > 0)) begin
        bad++; $display("FAIL i_read_rvalid[%0d]: got %b want %b", k, i_rvalid, k > 0);
      end
      if (k > 0) begin
        total++;
        if (i_rdata !== DATA_W'(k + 99)) begin
          bad++; $display("FAIL i_read_data[%0d]: got %0d want %0d", k, i_rdata, k + 99);
        end
      end
    end
  endtask

  task automatic test_d_priority();
    cyc(0, 1, 1, 12'd9, 1, 0, 12'd5, '0);
    total++;
    if ({i_gnt, d_gnt} !== 2'b01) begin bad++; $display("FAIL prio_both: got i=%b d=%b want i=0 d=1", i_gnt, d_gnt); end
    cyc(0, 1, 1, 12'd9, 0, 0, '0, '0);
    total++;
    if ({i_gnt, d_gnt, d_rvalid} !== 3'b101 || d_rdata !== 32'd105) begin
      bad++; $display("FAIL prio_d_resp: got ig=%b dg=%b drv=%b dd=%0d want 1 0 1 105", i_gnt, d_gnt, d_rvalid, d_rdata);
    end
    cyc(0, 1, 0, '0, 0, 0, '0, '0);
    total++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'd109) begin
      bad++; $display("FAIL prio_i_resp: got rv=%b d=%0d want 1 109", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_starve();
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 1, 12'd30, 1, 0, ADDR_W'(20 + k), '0);
      total++;
      if ({i_gnt, d_gnt} !== {k % 5 == 4, k % 5 != 4}) begin
        bad++; $display("FAIL starve_pat[%0d]: got i=%b d=%b want i=%b", k, i_gnt, d_gnt, k % 5 == 4);
      end
      total++;
      if ({i_rvalid, d_rvalid} !== {e_i_rvalid, e_d_rvalid} || i_rdata !== e_i_rdata || d_rdata !== e_d_rdata) begin
        bad++; $display("FAIL starve_resp[%0d]: got rv=%b%b i=%h d=%h want %b%b %h %h", k, i_rvalid, d_rvalid,
                        i_rdata, d_rdata, e_i_rvalid, e_d_rvalid, e_i_rdata, e_d_rdata);
      end
    end
    cyc(0, 1, 0, '0, 0, 0, '0, '0);
    total++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'd130) begin
      bad++; $display("FAIL starve_last: got rv=%b d=%0d want 1 130", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_store_load();
    cyc(0, 1, 0, '0, 1, 1, 12'd7, 32'hDEADBEEF);
    total++;
    if ({d_gnt, m_we} !== 2'b11 || m_addr !== 12'd7 || m_din !== 32'hDEADBEEF) begin
      bad++; $display("FAIL store_issue: got g=%b we=%b a=%0d d=%h want 1 1 7 deadbeef", d_gnt, m_we, m_addr, m_din);
    end
    cyc(0, 1, 0, '0, 1, 0, 12'd7, '0);
    total++;
    if ({d_gnt, d_rvalid, m_we} !== 3'b100) begin
      bad++; $display("FAIL store_no_rvalid: got g=%b rv=%b we=%b want 1 0 0", d_gnt, d_rvalid, m_we);
    end
    cyc(0, 1, 0, '0, 0, 0, '0, '0);
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL load_after_store: got rv=%b d=%h want 1 deadbeef", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    cyc(0, 1, 1, 12'd3, 0, 0, '0, '0);
    total++;
    if (i_gnt !== 1'b1) begin bad++; $display("FAIL rmr_gnt: got %b want 1", i_gnt); end
    cyc(1, 1, 0, '0, 0, 0, '0, '0);
    total++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_we} !== 5'b0 || i_rdata !== '0 || d_rdata !== '0) begin
      bad++; $display("FAIL rmr_in_reset: got %b%b%b%b%b i=%h d=%h want all 0", i_gnt, d_gnt, i_rvalid, d_rvalid,
                      m_we, i_rdata, d_rdata);
    end
    cyc(0, 1, 0, '0, 0, 0, '0, '0);
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b00 || i_rdata !== '0) begin
      bad++; $display("FAIL rmr_dropped: got rv=%b%b i=%h want 00 0", i_rvalid, d_rvalid, i_rdata);
    end
  endtask

  task automatic test_ce_hold();
    cyc(0, 1, 1, 12'd11, 0, 0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 12'd12, 1, 1, 12'd13, 32'h1234);
      total++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_we} !== 5'b0) begin
        bad++; $display("FAIL ce_off[%0d]: got %b%b%b%b%b want 00000", k, i_gnt, d_gnt, i_rvalid, d_rvalid, m_we);
      end
    end
    cyc(0, 1, 1, 12'd12, 0, 0, '0, '0);
    total++;
    if ({i_gnt, i_rvalid} !== 2'b11 || i_rdata !== 32'd111) begin
      bad++; $display("FAIL ce_resume: got g=%b rv=%b d=%0d want 1 1 111", i_gnt, i_rvalid, i_rdata);
    end
    cyc(0, 1, 0, '0, 0, 0, '0, '0);
    total++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'd112) begin
      bad++; $display("FAIL ce_next: got rv=%b d=%0d want 1 112", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_random();
    logic              ir, dr, dwe, r, c;
    logic [ADDR_W-1:0] ia, da;
    logic [DATA_W-1:0] dw;
    bit                i_busy, d_busy;
    logic [4:0]        got, want;
    i_busy = 0; d_busy = 0; ir = 0; dr = 0; dwe = 0; ia = '0; da = '0; dw = '0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 5) != 0);
      if (!i_busy || $urandom_range(0, 19) == 0) begin
        ir = ($urandom_range(0, 1) == 1);
        ia = ADDR_W'($urandom_range(0, 15));
      end
      if (!d_busy || $urandom_range(0, 19) == 0) begin
        dr  = ($urandom_range(0, 9) < 6);
        dwe = ($urandom_range(0, 2) == 0);
        da  = ADDR_W'($urandom_range(0, 15));
        dw  = DATA_W'($urandom);
      end
      cyc(r, c, ir, ia, dr, dwe, da, dw);
      got  = {i_gnt, d_gnt, i_rvalid, d_rvalid, m_we};
      want = {e_i_gnt, e_d_gnt, e_i_rvalid, e_d_rvalid, e_m_we};
      total++;
      if (got !== want) begin bad++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", n, got, want); end
      total++;
      if (i_gnt === 1'b1 && d_gnt === 1'b1) begin bad++; $display("FAIL rnd_two_gnt[%0d]: got 11 want at most one", n); end
      total++;
      if (i_rdata !== e_i_rdata || d_rdata !== e_d_rdata) begin
        bad++; $display("FAIL rnd_rdata[%0d]: got i=%h d=%h want i=%h d=%h", n, i_rdata, d_rdata, e_i_rdata, e_d_rdata);
      end
      total++;
      if (m_addr !== (e_d_gnt ? da : ia)) begin
        bad++; $display("FAIL rnd_maddr[%0d]: got %0d want %0d", n, m_addr, e_d_gnt ? da : ia);
      end
      i_busy = ir && !e_i_gnt;
      d_busy = dr && !e_d_gnt;
    end
  endtask

  initial begin
    rst = 1; ce = 0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    cnt = 0; pend_v = 0; pend_is_d = 0; pend_data = '0; hold_i = '0; hold_d = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      mem[k]     = DATA_W'(k + 100);
      ref_mem[k] = DATA_W'(k + 100);
    end
    test_reset();
    test_i_reads();
    test_d_priority();
    test_starve();
    test_store_load();
    test_reset_mid_read();
    test_ce_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
